sha256_round_sequencer: RTL and testbench
=========================================

Name: sha256_round_sequencer

Overview:
Control-side driver for the SHA-256 compression datapath. It accepts a start request with a block count, then sequences each 512-bit block through INIT, 64 rounds and hash update. It issues the round index, message-word requests, schedule-phase select and hash-update strobes, and signals completion with a one-cycle done pulse. Its round counter counts up and is gated by datapath readiness.

Parameters:
NUM_ROUNDS, 64, compression rounds per block
LOAD_WORDS, 16, rounds that take W directly from the message; the remaining rounds use the expanded schedule
IDX_W, 6, round index width; must satisfy 2**IDX_W >= NUM_ROUNDS
BLK_W, 7, block count and block index width

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
start  in  1  request to begin hashing; sampled only in IDLE
num_blocks  in  BLK_W  number of blocks to process; latched on an accepted start
step_en  in  1  datapath ready; when low, round progress stalls
busy  out  1  high in every state except IDLE
init_hash  out  1  one-cycle pulse in INIT of block 0; datapath loads H0 constants
init_block  out  1  one-cycle pulse in every INIT; datapath loads a..h from H
round_valid  out  1  high in ROUND
round_idx  out  IDX_W  current round, 0..NUM_ROUNDS-1
use_msg  out  1  round_valid && round_idx < LOAD_WORDS
msg_req  out  1  use_msg && step_en; consumes one message word
update_hash  out  1  one-cycle pulse in FINAL; datapath adds a..h into H
block_idx  out  BLK_W  index of the current block
done  out  1  one-cycle pulse in DONE

Behaviour:
- States: IDLE, INIT, ROUND, FINAL, DONE. Outputs are Moore-decoded from registered state, except msg_req, which is Mealy on step_en.
- Reset (asynchronous): state goes to IDLE; round_idx, block_idx and the latched block count clear to 0; all strobes are 0 and busy is 0. A reset during any state aborts the operation, with no done and no update_hash.
- IDLE: on start=1 with num_blocks!=0, latch num_blocks, clear block_idx and go to INIT.
  - start with num_blocks==0 is ignored: stay in IDLE, no done.
- INIT (one cycle): init_block=1, and init_hash=1 when block_idx==0. round_idx is cleared to 0. Next state is ROUND.
- ROUND: round_valid=1.
  - step_en=0: hold round_idx and state.
  - step_en=1 and round_idx<NUM_ROUNDS-1: increment round_idx.
  - step_en=1 and round_idx==NUM_ROUNDS-1: go to FINAL. round_idx never wraps and never exceeds NUM_ROUNDS-1.
- FINAL (one cycle): update_hash=1.
  - If block_idx==latched-1, go to DONE.
  - Otherwise increment block_idx and go to INIT.
- DONE (one cycle): done=1, then go to IDLE. block_idx holds its last value until the next accepted start.
- start in any non-IDLE state is ignored. start asserted in the same cycle as DONE is also ignored; it is accepted only on the following IDLE cycle.
- step_en affects only ROUND; INIT, FINAL and DONE advance unconditionally.
- Latency with step_en held high: start sampled at edge 0. INIT occupies cycle 1 and rounds occupy cycles 2..65 for block 0. Each block takes 66 cycles (INIT + 64 rounds + FINAL). done is high in cycle 66*N+1.
- Every stalled cycle in ROUND adds exactly one cycle of latency.
- msg_req fires exactly LOAD_WORDS times per block.

Decomposition:
- Shared package sha256_ctrl_pkg holds the state enum (IDLE, INIT, ROUND, FINAL, DONE) and the constants SHA256_NUM_ROUNDS=64 and SHA256_LOAD_WORDS=16.
- One natural sub-module is round_index_counter: an up-counter with synchronous clear, enable and terminal-count flag (idx==NUM_ROUNDS-1). The FSM instantiates it for round_idx.

Test Plan:
- Reset mid-ROUND: assert reset at round 30 -> same cycle busy=0, round_idx=0 and state IDLE; no done or update_hash follows.
- Single block, step_en=1: start with num_blocks=1 -> init_hash and init_block high in cycle 1; round_idx counts 0..63 over cycles 2..65; msg_req high for 16 cycles; update_hash in cycle 66; done in cycle 67.
- Three blocks: num_blocks=3 -> init_hash pulses once; init_block pulses 3 times; update_hash pulses 3 times; block_idx steps 0,1,2; done in cycle 199.
- Stall: step_en low for 5 cycles at round 15 and 3 cycles at round 63 -> round_idx holds through each stall; msg_req count is still 16; done in cycle 75.
- Ignored requests: start with num_blocks=0 -> no busy, no done. start pulsed during ROUND and during DONE -> no effect; only the first run completes.
- Boundary: num_blocks=127 -> block_idx reaches 126 without wrapping; exactly 127 update_hash pulses; done in cycle 8383.

Source files
------------

// File: rtl/sha256_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : sha256_ctrl_pkg
//  Purpose  : Shared constants and state encoding for the SHA-256 round
//             sequencer (control side of the compression datapath).
//  Contents : SHA256_NUM_ROUNDS, SHA256_LOAD_WORDS, state_t and the five
//             sequencer states.
//  Revision : 1.0  initial release
// ============================================================================
package sha256_ctrl_pkg;

  localparam int SHA256_NUM_ROUNDS = 64;
  localparam int SHA256_LOAD_WORDS = 16;

  // Sequencer state encoding (explicit 3-bit width)
  typedef logic [2:0] state_t;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_INIT  = 3'd1;
  localparam logic [2:0] ST_ROUND = 3'd2;
  localparam logic [2:0] ST_FINAL = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

endpackage
`default_nettype wire

// File: rtl/round_index_counter.sv
`default_nettype none
// ============================================================================
//  Module   : round_index_counter
//  Purpose  : Round index up-counter with synchronous clear, count enable and
//             terminal-count flag. Saturates at NUM_ROUNDS-1 so the index
//             never wraps.
//  Ports    : clock, reset (async, active-high), clear, enable  -> inputs
//             idx [IDX_W-1:0], terminal (idx == NUM_ROUNDS-1)   -> outputs
//  Revision : 1.0  initial release
// ============================================================================
module round_index_counter #(
  parameter int NUM_ROUNDS = 64,
  parameter int IDX_W      = 6
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             enable,
  output logic [IDX_W-1:0] idx,
  output logic             terminal
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ROUNDS - 1);

  assign terminal = (idx == LAST_IDX);

  // Clear wins over enable; the terminal gate keeps the index from wrapping
  // even if enable is held on the last round.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      idx <= '0;
    end else if (clear) begin
      idx <= '0;
    end else if (enable && !terminal) begin
      idx <= idx + IDX_W'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/sha256_round_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : sha256_round_sequencer
//  Purpose  : Sequences each 512-bit block through INIT, NUM_ROUNDS rounds and
//             a hash update, driving the SHA-256 compression datapath.
//  Ports    : clock, reset        clock / async active-high reset
//             start, num_blocks   request and block count (sampled in IDLE)
//             step_en             datapath ready, stalls round progress
//             busy                high outside IDLE
//             init_hash           INIT of block 0 (load H0 constants)
//             init_block          every INIT (load a..h from H)
//             round_valid         high in ROUND
//             round_idx           current round index
//             use_msg / msg_req   message-word phase / message-word consume
//             update_hash         FINAL strobe (add a..h into H)
//             block_idx           current block index
//             done                one-cycle completion pulse
//  Revision : 1.0  initial release
// ============================================================================
module sha256_round_sequencer
  import sha256_ctrl_pkg::*;
#(
  parameter int NUM_ROUNDS = SHA256_NUM_ROUNDS,
  parameter int LOAD_WORDS = SHA256_LOAD_WORDS,
  parameter int IDX_W      = 6,
  parameter int BLK_W      = 7
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [BLK_W-1:0] num_blocks,
  input  logic             step_en,
  output logic             busy,
  output logic             init_hash,
  output logic             init_block,
  output logic             round_valid,
  output logic [IDX_W-1:0] round_idx,
  output logic             use_msg,
  output logic             msg_req,
  output logic             update_hash,
  output logic [BLK_W-1:0] block_idx,
  output logic             done
);

  // One extra bit so LOAD_WORDS == 2**IDX_W still compares correctly
  localparam logic [IDX_W:0] LOAD_LIM = (IDX_W + 1)'(LOAD_WORDS);

  state_t           state;
  state_t           state_nxt;
  logic [BLK_W-1:0] blocks_lat;
  logic             round_last;
  logic             start_ok;
  logic             last_block;

  assign start_ok   = (state == ST_IDLE) && start && (num_blocks != '0);
  assign last_block = (block_idx == (blocks_lat - BLK_W'(1)));

  // Moore decode from registered state; msg_req alone looks at step_en
  assign busy        = (state != ST_IDLE);
  assign init_block  = (state == ST_INIT);
  assign init_hash   = (state == ST_INIT) && (block_idx == '0);
  assign round_valid = (state == ST_ROUND);
  assign update_hash = (state == ST_FINAL);
  assign done        = (state == ST_DONE);
  assign use_msg     = round_valid && ({1'b0, round_idx} < LOAD_LIM);
  assign msg_req     = use_msg && step_en;

  round_index_counter #(
    .NUM_ROUNDS (NUM_ROUNDS),
    .IDX_W      (IDX_W)
  ) u_round_cnt (
    .clock    (clock),
    .reset    (reset),
    .clear    (state == ST_INIT),
    .enable   (round_valid && step_en),
    .idx      (round_idx),
    .terminal (round_last)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (start_ok) state_nxt = ST_INIT;
      ST_INIT:  state_nxt = ST_ROUND;
      ST_ROUND: if (step_en && round_last) state_nxt = ST_FINAL;
      ST_FINAL: state_nxt = last_block ? ST_DONE : ST_INIT;
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      blocks_lat <= '0;
      block_idx  <= '0;
    end else begin
      state <= state_nxt;
      if (start_ok) begin
        blocks_lat <= num_blocks;
        block_idx  <= '0;
      end else if ((state == ST_FINAL) && !last_block) begin
        block_idx <= block_idx + BLK_W'(1);
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sha256_round_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sha256_round_sequencer
//  Purpose  : Self-checking bench for sha256_round_sequencer. Expected strobe
//             events (INIT, FINAL, DONE with cycle and block index) are queued
//             when a start is driven and popped as the DUT emits them.
//  Revision : 1.0  initial release
// ============================================================================
module tb_sha256_round_sequencer;
  import sha256_ctrl_pkg::*;

  localparam int IDX_W = 6;
  localparam int BLK_W = 7;
  localparam int NR    = SHA256_NUM_ROUNDS;
  localparam int LW    = SHA256_LOAD_WORDS;
  localparam int BLK_CYC = NR + 2;

  logic             clock = 1'b0;
  logic             reset;
  logic             start;
  logic [BLK_W-1:0] num_blocks;
  logic             step_en;
  logic             busy, init_hash, init_block, round_valid, use_msg;
  logic             msg_req, update_hash, done;
  logic [IDX_W-1:0] round_idx;
  logic [BLK_W-1:0] block_idx;

  sha256_round_sequencer #(
    .NUM_ROUNDS (NR),
    .LOAD_WORDS (LW),
    .IDX_W      (IDX_W),
    .BLK_W      (BLK_W)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .num_blocks  (num_blocks),
    .step_en     (step_en),
    .busy        (busy),
    .init_hash   (init_hash),
    .init_block  (init_block),
    .round_valid (round_valid),
    .round_idx   (round_idx),
    .use_msg     (use_msg),
    .msg_req     (msg_req),
    .update_hash (update_hash),
    .block_idx   (block_idx),
    .done        (done)
  );

  always #5 clock = ~clock;

  // kind: 0 = INIT (init_block), 1 = FINAL (update_hash), 2 = DONE
  typedef struct {
    int kind;
    int cyc;
    int blk;
  } ev_t;

  ev_t exp_q[$];
  int  tests_run = 0;
  int  fails     = 0;
  int  cyc;

  // Cycle 1 is the cycle after the edge that samples start. Stall cycles all
  // fall inside block 0's rounds, so they shift every event from FINAL of
  // block 0 onward.
  task automatic push_expected(input int nb, input int stall);
    ev_t e;
    for (int b = 0; b < nb; b++) begin
      e.kind = 0; e.cyc = 1 + BLK_CYC * b + ((b > 0) ? stall : 0); e.blk = b;
      exp_q.push_back(e);
      e.kind = 1; e.cyc = BLK_CYC * (b + 1) + stall; e.blk = b;
      exp_q.push_back(e);
    end
    e.kind = 2; e.cyc = BLK_CYC * nb + 1 + stall; e.blk = nb - 1;
    exp_q.push_back(e);
  endtask

  task automatic run_op(input string name, input int nb,
                        input int sa_at, input int sa_len,
                        input int sb_at, input int sb_len,
                        input int spur_round, input bit spur_done);
    int   stall_left, msg_cnt, exp_round, limit;
    bit   did_a, did_b, did_spur, got_done;
    logic exp_ih, s;
    ev_t  e;

    push_expected(nb, sa_len + sb_len);
    @(negedge clock);
    start = 1'b1; num_blocks = BLK_W'(nb); step_en = 1'b1;
    @(posedge clock);
    #1 start = 1'b0;
    cyc = 0; stall_left = 0; msg_cnt = 0; exp_round = 0;
    did_a = 0; did_b = 0; did_spur = 0; got_done = 0;
    limit = BLK_CYC * nb + 1 + sa_len + sb_len + 10;

    while (!got_done && cyc < limit) begin
      @(negedge clock);
      cyc++;
      start = 1'b0;
      if (round_valid && !did_spur && spur_round >= 0 && int'(round_idx) == spur_round) begin
        start = 1'b1; num_blocks = BLK_W'(5); did_spur = 1;
      end
      if (round_valid && !did_a && sa_len > 0 && int'(round_idx) == sa_at) begin
        stall_left = sa_len; did_a = 1;
      end
      if (round_valid && !did_b && sb_len > 0 && int'(round_idx) == sb_at) begin
        stall_left = sb_len; did_b = 1;
      end
      if (stall_left > 0) begin
        step_en = 1'b0; stall_left--;
      end else begin
        step_en = 1'b1;
      end
      #1;

      tests_run++;
      if (busy !== 1'b1) begin
        fails++; $display("FAIL %s busy cyc=%0d got=%b exp=1", name, cyc, busy);
      end

      if (round_valid === 1'b1) begin
        tests_run++;
        if (int'(round_idx) !== exp_round) begin
          fails++; $display("FAIL %s round_idx cyc=%0d got=%0d exp=%0d", name, cyc, round_idx, exp_round);
        end
        tests_run++;
        if (msg_req !== ((exp_round < LW) && step_en)) begin
          fails++; $display("FAIL %s msg_req cyc=%0d got=%b exp=%b", name, cyc, msg_req, ((exp_round < LW) && step_en));
        end
        if (step_en && exp_round < NR - 1) exp_round++;
      end else begin
        tests_run++;
        if (msg_req !== 1'b0) begin
          fails++; $display("FAIL %s msg_req_outside_round cyc=%0d got=%b exp=0", name, cyc, msg_req);
        end
      end
      if (msg_req === 1'b1) msg_cnt++;

      exp_ih = 1'b0;
      for (int k = 0; k < 3; k++) begin
        s = (k == 0) ? init_block : (k == 1) ? update_hash : done;
        if (s === 1'b1) begin
          tests_run++;
          if (exp_q.size() == 0) begin
            fails++; $display("FAIL %s unexpected_strobe kind=%0d cyc=%0d got=1 exp=0", name, k, cyc);
          end else begin
            e = exp_q.pop_front();
            if (e.kind != k || e.cyc != cyc || block_idx !== BLK_W'(e.blk)) begin
              fails++;
              $display("FAIL %s event got kind=%0d cyc=%0d blk=%0d exp kind=%0d cyc=%0d blk=%0d",
                       name, k, cyc, block_idx, e.kind, e.cyc, e.blk);
            end
            if (k == 0) begin
              exp_ih = (e.blk == 0);
              exp_round = 0;
            end
            if (k == 1) begin
              tests_run++;
              if (msg_cnt != LW) begin
                fails++; $display("FAIL %s msg_count blk=%0d got=%0d exp=%0d", name, e.blk, msg_cnt, LW);
              end
              msg_cnt = 0;
            end
            if (k == 2) got_done = 1;
          end
        end
      end
      tests_run++;
      if (init_hash !== exp_ih) begin
        fails++; $display("FAIL %s init_hash cyc=%0d got=%b exp=%b", name, cyc, init_hash, exp_ih);
      end

      if (got_done && spur_done) begin
        start = 1'b1; num_blocks = BLK_W'(3);
      end
    end

    tests_run++;
    if (!got_done) begin
      fails++; $display("FAIL %s done_timeout got=none exp=cyc %0d", name, BLK_CYC * nb + 1 + sa_len + sb_len);
    end

    // Back in IDLE: nothing may restart or strobe
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      start = 1'b0;
      #1;
      tests_run++;
      if (busy !== 1'b0 || done !== 1'b0 || update_hash !== 1'b0 || init_block !== 1'b0) begin
        fails++;
        $display("FAIL %s idle_after busy=%b done=%b upd=%b init=%b exp all 0", name, busy, done, update_hash, init_block);
      end
    end
    tests_run++;
    if (exp_q.size() != 0) begin
      fails++; $display("FAIL %s leftover_events got=%0d exp=0", name, exp_q.size());
    end
    exp_q.delete();
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; num_blocks = '0; step_en = 1'b1;
    #1;
    tests_run++;
    if (busy !== 1'b0 || done !== 1'b0 || update_hash !== 1'b0 || init_block !== 1'b0 ||
        init_hash !== 1'b0 || round_valid !== 1'b0 || msg_req !== 1'b0 ||
        round_idx !== '0 || block_idx !== '0) begin
      fails++;
      $display("FAIL reset_state busy=%b done=%b upd=%b ib=%b ih=%b rv=%b mr=%b ridx=%0d bidx=%0d exp all 0",
               busy, done, update_hash, init_block, init_hash, round_valid, msg_req, round_idx, block_idx);
    end
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic test_single_block();
    run_op("single", 1, -1, 0, -1, 0, -1, 0);
  endtask

  task automatic test_three_blocks();
    run_op("three", 3, -1, 0, -1, 0, -1, 0);
  endtask

  task automatic test_stall();
    run_op("stall", 1, 15, 5, 63, 3, -1, 0);
  endtask

  task automatic test_ignored();
    @(negedge clock);
    start = 1'b1; num_blocks = '0;
    @(negedge clock);
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      tests_run++;
      if (busy !== 1'b0 || done !== 1'b0) begin
        fails++; $display("FAIL zero_blocks busy=%b done=%b exp 0 0", busy, done);
      end
      @(negedge clock);
    end
    run_op("spurious", 1, -1, 0, -1, 0, 10, 1);
  endtask

  task automatic test_reset_mid_round();
    int  n;
    bool_found:
    begin end
    n = 0;
    @(negedge clock);
    start = 1'b1; num_blocks = BLK_W'(2); step_en = 1'b1;
    @(negedge clock);
    start = 1'b0;
    while (!(round_valid === 1'b1 && round_idx == IDX_W'(30)) && n < 200) begin
      @(negedge clock);
      n++;
    end
    tests_run++;
    if (n >= 200) begin
      fails++; $display("FAIL reset_mid reach_round30 got=timeout exp=round 30");
    end
    #1 reset = 1'b1;
    #1;
    tests_run++;
    if (busy !== 1'b0 || round_idx !== '0 || round_valid !== 1'b0 || block_idx !== '0 ||
        done !== 1'b0 || update_hash !== 1'b0) begin
      fails++;
      $display("FAIL reset_mid busy=%b ridx=%0d rv=%b bidx=%0d done=%b upd=%b exp all 0",
               busy, round_idx, round_valid, block_idx, done, update_hash);
    end
    @(negedge clock);
    reset = 1'b0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clock);
      #1;
      tests_run++;
      if (busy !== 1'b0 || done !== 1'b0 || update_hash !== 1'b0) begin
        fails++; $display("FAIL reset_mid_after busy=%b done=%b upd=%b exp 0 0 0", busy, done, update_hash);
      end
    end
  endtask

  task automatic test_max_blocks();
    run_op("max_blocks", 127, -1, 0, -1, 0, -1, 0);
  endtask

  initial begin
    test_reset();
    test_single_block();
    test_three_blocks();
    test_stall();
    test_ignored();
    test_reset_mid_round();
    test_max_blocks();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
`default_nettype wire
